// File: rtl/random_delay_pkg.sv
// Shared types and constants for the random-interval timer.
package random_delay_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, EXPIRED} rdt_state_t;

  // Board defaults: 100 MHz clock, 1 ms tick, 2..4.999 s interval.
  localparam int RDT_TICK_DIV_DEFAULT = 100_000;
  localparam int RDT_MIN_MS_DEFAULT   = 2000;
  localparam int RDT_SPAN_MS_DEFAULT  = 3000;

  // Maximal-length Fibonacci tap masks (bit i set = q[i] feeds the XOR).
  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
      16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
      24:      return 32'h00E1_0000;  // x^24+x^23+x^22+x^17+1
      32:      return 32'h8020_0003;  // x^32+x^22+x^2+x^1+1
      default: return 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/random_delay_timer_lfsr.sv
// Free-running Fibonacci LFSR; shifts every cycle out of reset.
module lfsr
  import random_delay_pkg::*;
#(
  parameter int             W    = 16,
  parameter logic [W-1:0]   SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic [W-1:0] q
);

  localparam logic [31:0]  TAPS_ALL = lfsr_taps(W);
  localparam logic [W-1:0] TAPS     = TAPS_ALL[W-1:0];

  if (SEED == '0) begin : g_bad_seed
    $error("lfsr: SEED must be non-zero");
  end
  if (W != 8 && W != 16 && W != 24 && W != 32) begin : g_bad_width
    $error("lfsr: W must be 8, 16, 24 or 32");
  end

  logic [W-1:0] q_q, q_d;

  // Shift left, feedback into bit 0; a non-zero seed never reaches zero.
  always_comb begin
    q_d = {q_q[W-2:0], ^(q_q & TAPS)};
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= SEED;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/random_delay_timer.sv
// Random-interval timer: draws an interval from the LFSR on start,
// counts it down in ms ticks, then raises delay and pulses done.
module random_delay_timer
  import random_delay_pkg::*;
#(
  parameter int                TICK_DIV = RDT_TICK_DIV_DEFAULT,
  parameter int                LFSR_W   = 16,
  parameter logic [LFSR_W-1:0] SEED     = LFSR_W'(16'hACE1),
  parameter int                MIN_MS   = RDT_MIN_MS_DEFAULT,
  parameter int                SPAN_MS  = RDT_SPAN_MS_DEFAULT,
  parameter int                MS_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            cancel,
  output logic            busy,
  output logic            delay,
  output logic            done,
  output logic [MS_W-1:0] delay_ms
);

  localparam int SW    = $clog2(SPAN_MS + 1);
  localparam int PW    = LFSR_W + SW;
  localparam int PSC_W = $clog2(TICK_DIV);

  if (TICK_DIV < 2 || MIN_MS < 1 || SPAN_MS < 1 ||
      ((64'(MIN_MS) + 64'(SPAN_MS)) >> MS_W) != 0) begin : g_bad_params
    $error("random_delay_timer: illegal TICK_DIV/MIN_MS/SPAN_MS/MS_W");
  end

  logic [LFSR_W-1:0] lfsr_q;

  lfsr #(.W(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_q)
  );

  rdt_state_t       state_q, state_d;
  logic [PSC_W-1:0] presc_q, presc_d;
  logic [MS_W-1:0]  ms_left_q, ms_left_d;
  logic [MS_W-1:0]  delay_ms_q, delay_ms_d;
  logic             busy_q, delay_q, done_q;
  logic [PW-1:0]    prod_sh;
  logic [MS_W-1:0]  draw;
  logic             tick;

  // Scale the LFSR into [0, SPAN_MS) by multiply-and-shift, then offset.
  always_comb begin
    prod_sh = (PW'(lfsr_q) * PW'(SPAN_MS)) >> LFSR_W;
    draw    = MS_W'(MIN_MS) + MS_W'(prod_sh);
  end

  // Next-state logic; cancel has priority over start and over the final tick.
  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    ms_left_d  = ms_left_q;
    delay_ms_d = delay_ms_q;
    tick       = (presc_q == PSC_W'(TICK_DIV - 1));
    case (state_q)
      IDLE, EXPIRED: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (start) begin
          state_d    = WAIT;
          delay_ms_d = draw;
          ms_left_d  = draw;
          presc_d    = '0;
        end
      end
      WAIT: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          presc_d = tick ? '0 : presc_q + PSC_W'(1);
          if (tick) begin
            ms_left_d = ms_left_q - MS_W'(1);
            if (ms_left_q == MS_W'(1)) state_d = EXPIRED;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      ms_left_q  <= '0;
      delay_ms_q <= '0;
      busy_q     <= 1'b0;
      delay_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      ms_left_q  <= ms_left_d;
      delay_ms_q <= delay_ms_d;
      busy_q     <= (state_d == WAIT);
      delay_q    <= (state_d == EXPIRED);
      done_q     <= (state_q == WAIT) && (state_d == EXPIRED);
    end
  end

  assign busy     = busy_q;
  assign delay    = delay_q;
  assign done     = done_q;
  assign delay_ms = delay_ms_q;

endmodule

// File: tb/tb_random_delay_timer.sv
// Directed bench for random_delay_timer with a tiny tick divider.
module tb_random_delay_timer;
  import random_delay_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       busy, delay, done;
  logic [7:0] delay_ms;

  always #5 clk = ~clk;

  random_delay_timer #(
    .TICK_DIV(4), .LFSR_W(16), .SEED(16'hACE1),
    .MIN_MS(2), .SPAN_MS(4), .MS_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .busy(busy), .delay(delay), .done(done), .delay_ms(delay_ms)
  );

  // Reference LFSR written straight from the tap equation.
  logic [15:0] m_lfsr;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lfsr_next(m_lfsr);

  function automatic int draw_of(input logic [15:0] v);
    return 2 + ((int'(v) * 4) >>> 16);
  endfunction

  int n_cmp = 0;
  int n_bad = 0;
  int last_ms = 0;
  int seen [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // One start/expire run; optional extra start during WAIT at edge k+restart_at.
  task automatic run_one(input int restart_at, output int ms);
    int exp, n;
    logic early;
    exp = draw_of(m_lfsr);
    start = 1'b1; step(); start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("delay_drop", delay, 0);
    chk("delay_ms_draw", delay_ms, exp);
    chk("delay_ms_range", (delay_ms >= 2 && delay_ms <= 5), 1);
    n = 0; early = 1'b0;
    while (!delay && n < 100) begin
      if (restart_at > 0 && n + 1 == restart_at) start = 1'b1;
      step(); start = 1'b0; n++;
      if (done && !delay) early = 1'b1;
    end
    chk("no_early_done", early, 0);
    chk("expiry_latency", n, exp * 4);
    chk("done_rise", done, 1);
    chk("busy_fall", busy, 0);
    chk("delay_ms_hold", delay_ms, exp);
    step();
    chk("done_one_cycle", done, 0);
    chk("delay_level", delay, 1);
    ms = exp;
    last_ms = exp;
  endtask

  initial begin
    int ms, exp;
    logic bad;

    // Power-on reset.
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_delay", delay, 0);
    chk("rst_done", done, 0);
    chk("rst_delay_ms", delay_ms, 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // Reset asserted mid-countdown clears everything asynchronously.
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_delay", delay, 0);
    chk("midrst_done", done, 0);
    chk("midrst_delay_ms", delay_ms, 0);
    chk("midrst_state", 32'(dut.state_q), 32'(IDLE));
    @(negedge clk) rst_n = 1'b1;
    step();

    // LFSR follows the reference sequence and never reaches zero.
    for (int i = 0; i < 100; i++) begin
      chk("lfsr_seq", dut.lfsr_q, m_lfsr);
      chk("lfsr_nonzero", (dut.lfsr_q != 16'h0), 1);
      step();
    end

    // Basic draw / latency, then restart directly from EXPIRED.
    run_one(0, ms);
    run_one(0, ms);

    // start during WAIT is ignored.
    run_one(2, ms);

    // Cancel three cycles after start.
    exp = draw_of(m_lfsr);
    start = 1'b1; step(); start = 1'b0;
    chk("cancel_draw", delay_ms, exp);
    last_ms = exp;
    step(); step();
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("cancel_busy", busy, 0);
    chk("cancel_state", 32'(dut.state_q), 32'(IDLE));
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done || delay || busy) bad = 1'b1;
    end
    chk("cancel_quiet", bad, 0);

    // start and cancel together from IDLE.
    start = 1'b1; cancel = 1'b1; step(); start = 1'b0; cancel = 1'b0;
    chk("sc_busy", busy, 0);
    chk("sc_state", 32'(dut.state_q), 32'(IDLE));
    chk("sc_delay_ms", delay_ms, last_ms);
    step();
    chk("sc_busy_later", busy, 0);

    // Cancel on the final tick suppresses expiry.
    exp = draw_of(m_lfsr);
    start = 1'b1; step(); start = 1'b0;
    for (int i = 1; i < exp * 4; i++) step();
    chk("busy_before_final", busy, 1);
    cancel = 1'b1; step(); cancel = 1'b0;
    chk("ft_done", done, 0);
    chk("ft_delay", delay, 0);
    chk("ft_busy", busy, 0);
    chk("ft_state", 32'(dut.state_q), 32'(IDLE));
    step();
    chk("ft_done_later", done, 0);
    chk("ft_delay_later", delay, 0);

    // Distribution over many back-to-back runs.
    for (int i = 0; i < 4; i++) seen[i] = 0;
    for (int i = 0; i < 1000; i++) begin
      run_one(0, ms);
      if (delay_ms >= 2 && delay_ms <= 5) seen[delay_ms - 2]++;
    end
    for (int i = 0; i < 4; i++) chk("dist_value_seen", (seen[i] > 0), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
